// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the HI/LO control stage.
// MULDIV_MADD_EN enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package muldiv_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MFHI  = 4'd3;
    localparam logic [3:0] OP_MFLO  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_t;

    // Ops that launch the multiplier; accumulate ops only when the feature is built in.
    function automatic logic is_mul(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU:                       return 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:    return 1'b1;
`endif
            OP_NONE:                                 return 1'b0;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic acc_t acc_kind(input logic [3:0] op);
        case (op)
            OP_MADD, OP_MADDU: return ACC_ADD;
            OP_MSUB, OP_MSUBU: return ACC_SUB;
            default:           return ACC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO storage with the MTHI/MTLO write path and the product commit mux.
// The product commit wins over moves; the two never coincide in a single-issue pipeline.
module muldiv_ctrl_hilo_regs
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        commit,
    input  acc_t        acc,
    input  logic [63:0] prod,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] commit_val;

    always_comb begin
        commit_val = prod;
        case (acc)
            ACC_ADD: commit_val = {hi, lo} + prod;
            ACC_SUB: commit_val = {hi, lo} - prod;
            default: commit_val = prod;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            {hi, lo} <= commit_val;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO control stage: launches the external shift-add multiplier, stalls EX until the
// product returns and commits it to HI/LO. MULDIV_MADD_EN adds the accumulate ops.
//
// state  | meaning
// IDLE   | no multiply outstanding; issues multiplies, serves moves
// LAUNCH | start cycle done, multiplier ready not yet dropped
// WAIT   | multiply running; commits on mul_ready
// DRAIN  | flushed multiply still running; result discarded
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] rdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic        mul_ready,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo
);

    state_t state_q, state_d;
    acc_t   acc_q, acc_d;
    logic   go, issue_mul, commit, mv_ok, hi_we, lo_we;

    assign go        = ex_valid & ~flush & ~reset;
    assign issue_mul = go & is_mul(ex_op);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= ACC_NONE;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mul_start = 1'b0;
        stall_o   = 1'b0;
        commit    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_mul) begin
                        stall_o = 1'b1;
                        if (mul_ready) begin
                            mul_start = 1'b1;
                            acc_d     = acc_kind(ex_op);
                            state_d   = ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    stall_o = 1'b1;
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    stall_o = ~mul_ready;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end else if (mul_ready) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Only a newly presented multiply has to wait for the orphaned one.
                    stall_o = issue_mul;
                    if (mul_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign mv_ok = go & ((state_q == ST_IDLE) | (state_q == ST_DRAIN));
    assign hi_we = mv_ok & (ex_op == OP_MTHI);
    assign lo_we = mv_ok & (ex_op == OP_MTLO);

    assign mul_a      = ex_rs;
    assign mul_b      = ex_rt;
    assign mul_signed = issue_mul & is_signed(ex_op);
    assign rdata      = (ex_op == OP_MFHI) ? hi_o : lo_o;

    muldiv_ctrl_hilo_regs u_hilo (
        .clock  (clock),
        .reset  (reset),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (ex_rs),
        .commit (commit),
        .acc    (acc_q),
        .prod   ({mul_hi, mul_lo}),
        .hi     (hi_o),
        .lo     (lo_o)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a 33-cycle behavioural multiplier attached.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_op = 4'd0;
    logic [31:0] ex_rs = 32'd0;
    logic [31:0] ex_rt = 32'd0;
    logic        flush = 1'b0;
    logic        stall_o, mul_start, mul_signed, mul_ready;
    logic [31:0] rdata, hi_o, lo_o, mul_a, mul_b, mul_hi, mul_lo;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    muldiv_ctrl dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .stall_o(stall_o),
        .rdata(rdata), .hi_o(hi_o), .lo_o(lo_o), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
        .mul_ready(mul_ready), .mul_hi(mul_hi), .mul_lo(mul_lo)
    );

    // Multiplier: ready drops for 32 cycles after a start, product held until next start.
    logic [5:0]  m_cnt;
    logic [63:0] m_prod;
    always_ff @(posedge clock) begin
        if (reset) begin
            m_cnt  <= 6'd0;
            m_prod <= 64'd0;
        end else if (mul_start && m_cnt == 6'd0) begin
            m_cnt  <= 6'd32;
            m_prod <= mul_signed ? ({{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b})
                                 : ({32'd0, mul_a} * {32'd0, mul_b});
        end else if (m_cnt != 6'd0) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end
    assign mul_ready = (m_cnt == 6'd0);
    assign mul_hi    = m_prod[63:32];
    assign mul_lo    = m_prod[31:0];

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl);
        @(negedge clock);
        ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = rt; flush = fl;
        #1;
    endtask

    // Issues a multiply and holds it in EX while stalled; n = first cycle with stall low.
    task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic started, output int n);
        drive(1'b1, op, a, b, 1'b0);
        started = mul_start;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            drive(1'b1, op, a, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", mul_start); end
        checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi_o, lo_o}); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_mult_signed();
        logic st; int n;
        run_mul(OP_MULT, 32'hFFFF_FFFF, 32'h2, st, n);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start got %b want 1", st); end
        checks++; if (n != 33) begin errors++; $display("FAIL mult_stall_len got %0d want 33", n); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mult_prod got %h want ffffffff_fffffffe", {hi_o, lo_o}); end
    endtask

    task automatic test_multu_mfhi();
        logic st; int n;
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'h2, st, n);
        checks++; if (n != 33) begin errors++; $display("FAIL multu_stall_len got %0d want 33", n); end
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL multu_mfhi got %h want 00000001", rdata); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mfhi_stall got %b want 0", stall_o); end
        checks++; if (lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo_o); end
    endtask

    task automatic test_mt_mf();
        drive(1'b1, OP_MTLO, 32'h1234, 32'd0, 1'b0);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mtlo_stall got %b want 0", stall_o); end
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL mflo got %h want 00001234", rdata); end
        checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL mtlo_hi_kept got %h want 00000001", hi_o); end
        drive(1'b1, OP_MTHI, 32'hABCD, 32'd0, 1'b0);
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        checks++; if (rdata !== 32'hABCD) begin errors++; $display("FAIL mfhi got %h want 0000abcd", rdata); end
        drive(1'b1, 4'd12, 32'h5, 32'h6, 1'b0);
        checks++; if ({stall_o, mul_start} !== 2'b00) begin errors++; $display("FAIL op12_idle got %b want 00", {stall_o, mul_start}); end
    endtask

    task automatic test_flush();
        int n, st;
        drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b1);
        checks++; if ({stall_o, mul_start} !== 2'b00) begin errors++; $display("FAIL issue_flush got %b want 00", {stall_o, mul_start}); end
        drive(1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0);
        drive(1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0);
        drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
        for (int c = 1; c <= 9; c++) drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
        drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b1);
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall_c11 got %b want 0", stall_o); end
        drive(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        n = 0; st = -1;
        while (stall_o === 1'b1 && n < 200) begin
            if (mul_start === 1'b1 && st < 0) st = n;
            n++;
            drive(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        end
        checks++; if (st != 22) begin errors++; $display("FAIL drain_restart got %0d want 22", st); end
        checks++; if (n != 55) begin errors++; $display("FAIL drain_stall_len got %0d want 55", n); end
        checks++; if ({hi_o, lo_o} !== 64'h11_0000_0022) begin errors++; $display("FAIL flush_hilo_kept got %h want 00000011_00000022", {hi_o, lo_o}); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL drain_prod got %h want ffffffff_ffffffeb", {hi_o, lo_o}); end
    endtask

    task automatic test_back_to_back();
        logic st; int n;
        run_mul(OP_MULTU, 32'd2, 32'd3, st, n);
        run_mul(OP_MULTU, 32'd4, 32'd5, st, n);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL b2b_start got %b want 1", st); end
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_stall_len got %0d want 33", n); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'd20) begin errors++; $display("FAIL b2b_prod got %h want 20", {hi_o, lo_o}); end
    endtask

    task automatic test_reset_mid();
        logic st; int n;
        drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
        for (int c = 1; c <= 4; c++) drive(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
        @(negedge clock); reset = 1'b1; ex_valid = 1'b0; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_cycle_stall got %b want 0", stall_o); end
        @(negedge clock); reset = 1'b0; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall_o); end
        checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo got %h want 0", {hi_o, lo_o}); end
        run_mul(OP_MULTU, 32'd6, 32'd7, st, n);
        checks++; if (st !== 1'b1 || n != 33) begin errors++; $display("FAIL rst_mid_reissue got start %b len %0d want 1 33", st, n); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if (lo_o !== 32'd42) begin errors++; $display("FAIL rst_mid_prod got %h want 0000002a", lo_o); end
    endtask

    task automatic test_madd();
`ifdef MULDIV_MADD_EN
        logic st; int n;
`endif
        drive(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
        drive(1'b1, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MULDIV_MADD_EN
        run_mul(OP_MADDU, 32'd1, 32'd1, st, n);
        checks++; if (st !== 1'b1 || n != 33) begin errors++; $display("FAIL maddu_timing got start %b len %0d want 1 33", st, n); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'h1_0000_0000) begin errors++; $display("FAIL maddu_acc got %h want 00000001_00000000", {hi_o, lo_o}); end
        run_mul(OP_MSUB, 32'd2, 32'd3, st, n);
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'h0_FFFF_FFFA) begin errors++; $display("FAIL msub_acc got %h want 00000000_fffffffa", {hi_o, lo_o}); end
`else
        drive(1'b1, OP_MADDU, 32'd1, 32'd1, 1'b0);
        checks++; if ({stall_o, mul_start} !== 2'b00) begin errors++; $display("FAIL maddu_off_idle got %b want 00", {stall_o, mul_start}); end
        drive(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        checks++; if ({hi_o, lo_o} !== 64'h0_FFFF_FFFF) begin errors++; $display("FAIL maddu_off_hilo got %h want 00000000_ffffffff", {hi_o, lo_o}); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_mfhi();
        test_mt_mf();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
